// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: bus request/response types,
// status-word bit positions and the frame-state encoding.
package uart_tx_pkg;

  // Peripheral bus request (master -> peripheral).
  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  // Peripheral bus response (peripheral -> master).
  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_error;
  } mem_out_type;

  // Bit positions inside the status word returned by a read.
  localparam int STATUS_BUSY      = 0;
  localparam int STATUS_HOLD_FULL = 1;

  // Serial frame state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Build the status word so every agent on the bus decodes it the same way.
  function automatic logic [31:0] status_word(input logic busy, input logic hold_full);
    logic [31:0] w;
    w                   = 32'h0000_0000;
    w[STATUS_BUSY]      = busy;
    w[STATUS_HOLD_FULL] = hold_full;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a one-entry holding register.
// All state lives in one registered struct; a single combinational block
// computes its next value, so every output is driven straight from a flop.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int clock_rate = 868
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  uart_in,
  output mem_out_type uart_out,
  output logic        uart_irpt,
  output logic        tx
);

  localparam int CW = (clock_rate > 2) ? $clog2(clock_rate) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(clock_rate - 1);

  typedef struct packed {
    uart_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shifter;
    logic [7:0]    hold;
    logic          hold_full;
    logic          tx;
    logic          irpt;
    logic          ready;
    logic [31:0]   rdata;
  } reg_t;

  localparam reg_t R_RST = '{
    state:     IDLE,
    cnt:       '0,
    bit_idx:   3'd0,
    shifter:   8'h00,
    hold:      8'h00,
    hold_full: 1'b0,
    tx:        1'b1,
    irpt:      1'b0,
    ready:     1'b0,
    rdata:     32'h0000_0000
  };

  reg_t r_q;
  reg_t r_d;

  logic wr_req_s;
  logic rd_req_s;
  logic busy_s;
  logic cnt_last_s;
  logic unused_bus_s;

  // Bus fields this peripheral has no use for (single register, byte data).
  assign unused_bus_s = ^{uart_in.mem_instr, uart_in.mem_addr, uart_in.mem_wdata[31:8]};

  // Next-state logic: bus handshake, bit timing and frame sequencing.
  always_comb begin
    r_d        = r_q;
    r_d.ready  = 1'b0;
    r_d.rdata  = 32'h0000_0000;
    r_d.irpt   = 1'b0;
    busy_s     = (r_q.state != IDLE);
    wr_req_s   = uart_in.mem_valid & (|uart_in.mem_wstrb);
    rd_req_s   = uart_in.mem_valid & ~(|uart_in.mem_wstrb);
    cnt_last_s = (r_q.cnt == CNT_LAST);

    // Writes only land in an empty holding register; a full one stalls the master.
    if (wr_req_s && !r_q.hold_full) begin
      r_d.hold      = uart_in.mem_wdata[7:0];
      r_d.hold_full = 1'b1;
      r_d.ready     = 1'b1;
    end else if (rd_req_s) begin
      r_d.ready = 1'b1;
      r_d.rdata = status_word(busy_s, r_q.hold_full);
    end else begin
      r_d.ready = 1'b0;
    end

    // Bit-period counter runs only while a frame is on the line.
    if (busy_s) begin
      r_d.cnt = cnt_last_s ? '0 : (r_q.cnt + CW'(1));
    end else begin
      r_d.cnt = '0;
    end

    // Holding register and writes are mutually exclusive on hold_full, so
    // loading the shifter here never collides with an accepted write above.
    case (r_q.state)
      IDLE: begin
        if (r_q.hold_full) begin
          r_d.shifter   = r_q.hold;
          r_d.hold_full = 1'b0;
          r_d.state     = START;
        end else begin
          r_d.state = IDLE;
        end
      end
      START: begin
        if (cnt_last_s) begin
          r_d.state   = DATA;
          r_d.bit_idx = 3'd0;
        end else begin
          r_d.state = START;
        end
      end
      DATA: begin
        if (cnt_last_s) begin
          if (r_q.bit_idx == 3'd7) begin
            r_d.state = STOP;
          end else begin
            r_d.bit_idx = r_q.bit_idx + 3'd1;
          end
        end else begin
          r_d.state = DATA;
        end
      end
      STOP: begin
        if (cnt_last_s) begin
          // Chain straight into the next start bit when a byte is waiting.
          if (r_q.hold_full) begin
            r_d.shifter   = r_q.hold;
            r_d.hold_full = 1'b0;
            r_d.state     = START;
          end else begin
            r_d.state = IDLE;
            r_d.irpt  = 1'b1;
          end
        end else begin
          r_d.state = STOP;
        end
      end
      default: begin
        r_d.state = IDLE;
      end
    endcase

    // Line level follows the state being entered, so tx is registered.
    case (r_d.state)
      START:   r_d.tx = 1'b0;
      DATA:    r_d.tx = r_d.shifter[r_d.bit_idx];
      default: r_d.tx = 1'b1;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= R_RST;
    end else begin
      r_q <= r_d;
    end
  end

  assign uart_out.mem_ready = r_q.ready;
  assign uart_out.mem_rdata = r_q.rdata;
  assign uart_out.mem_error = 1'b0;
  assign uart_irpt          = r_q.irpt;
  assign tx                 = r_q.tx;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with clock_rate = 4.
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int CR = 4;

  logic        clock;
  logic        reset;
  mem_in_type  uart_in;
  mem_out_type uart_out;
  logic        uart_irpt;
  logic        tx;

  int vectors;
  int miscompares;

  uart_tx #(.clock_rate(CR)) dut (
    .clock     (clock),
    .reset     (reset),
    .uart_in   (uart_in),
    .uart_out  (uart_out),
    .uart_irpt (uart_irpt),
    .tx        (tx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    uart_in.mem_valid = 1'b0;
    uart_in.mem_wstrb = 4'h0;
    uart_in.mem_wdata = 32'h0;
  endtask

  // Write issued in cycle N; checks the N+1 response, returns at cycle N+2.
  task automatic start_write(input logic [7:0] b);
    uart_in.mem_valid = 1'b1;
    uart_in.mem_wstrb = 4'hF;
    uart_in.mem_wdata = {24'h0, b};
    tick();
    chk("wr_ready", uart_out.mem_ready, 1'b1);
    chk("wr_rdata", uart_out.mem_rdata, 32'h0);
    bus_idle();
    tick();
  endtask

  // Read issued in the current cycle; checks the response one cycle later.
  task automatic do_read(input logic [31:0] exp);
    uart_in.mem_valid = 1'b1;
    uart_in.mem_wstrb = 4'h0;
    tick();
    chk("rd_ready", uart_out.mem_ready, 1'b1);
    chk("rd_status", uart_out.mem_rdata, exp);
    bus_idle();
  endtask

  // Checks frame cycles [from, upto) of byte b; optionally raises a write at
  // wr_idx and expects mem_ready exactly at rdy_idx (dropping valid there).
  task automatic run_frame(input logic [7:0] b, input int from, input int upto,
                           input int wr_idx, input logic [7:0] wr_data, input int rdy_idx);
    logic exp_tx;
    int   bp;
    for (int i = from; i < upto; i++) begin
      bp = i / CR;
      if (bp == 0) exp_tx = 1'b0;
      else if (bp == 9) exp_tx = 1'b1;
      else exp_tx = b[bp-1];
      if (i == wr_idx) begin
        uart_in.mem_valid = 1'b1;
        uart_in.mem_wstrb = 4'hF;
        uart_in.mem_wdata = {24'h0, wr_data};
      end
      chk("frame_tx", tx, exp_tx);
      chk("frame_irpt", uart_irpt, 1'b0);
      chk("frame_ready", uart_out.mem_ready, (i == rdy_idx));
      if (i == rdy_idx) begin
        chk("frame_wr_rdata", uart_out.mem_rdata, 32'h0);
        bus_idle();
      end
      tick();
    end
  endtask

  task automatic end_frame();
    chk("irpt_pulse", uart_irpt, 1'b1);
    chk("irpt_tx", tx, 1'b1);
    tick();
    chk("irpt_drop", uart_irpt, 1'b0);
    chk("idle_tx", tx, 1'b1);
  endtask

  initial begin
    int irpt_cnt;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    uart_in.mem_instr = 1'b0;
    uart_in.mem_addr  = 32'h0;
    bus_idle();
    tick();
    tick();
    chk("rst_tx", tx, 1'b1);
    chk("rst_irpt", uart_irpt, 1'b0);
    chk("rst_ready", uart_out.mem_ready, 1'b0);
    chk("rst_rdata", uart_out.mem_rdata, 32'h0);
    chk("rst_error", uart_out.mem_error, 1'b0);
    reset = 1'b0;
    tick();

    // Single frame 0x55; interrupt exactly at N+42.
    start_write(8'h55);
    run_frame(8'h55, 0, 40, -1, 8'h00, -1);
    end_frame();
    tick();

    // Back-to-back 0xA5 / 0x3C: contiguous frames, one interrupt.
    start_write(8'hA5);
    run_frame(8'hA5, 0, 40, 0, 8'h3C, 1);
    run_frame(8'h3C, 0, 40, -1, 8'h00, -1);
    end_frame();
    tick();

    // Third write 0xFF stalls until the second byte moves into the shifter.
    start_write(8'hA5);
    run_frame(8'hA5, 0, 20, 0, 8'h3C, 1);
    run_frame(8'hA5, 20, 40, 20, 8'hFF, -1);
    run_frame(8'h3C, 0, 40, -1, 8'h00, 1);
    run_frame(8'hFF, 0, 40, -1, 8'h00, -1);
    end_frame();
    tick();

    // Status reads: idle, busy with empty hold, busy with full hold.
    do_read(32'h0);
    tick();
    start_write(8'h12);
    do_read(32'h1);
    uart_in.mem_valid = 1'b1;
    uart_in.mem_wstrb = 4'hF;
    uart_in.mem_wdata = 32'h34;
    tick();
    chk("st_wr_ready", uart_out.mem_ready, 1'b1);
    bus_idle();
    do_read(32'h3);
    irpt_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (uart_irpt === 1'b1) irpt_cnt++;
    end
    chk("st_irpt_count", irpt_cnt, 32'd1);
    chk("st_drain_tx", tx, 1'b1);
    do_read(32'h0);
    tick();

    // Reset in the middle of the data bits of 0x81.
    start_write(8'h81);
    run_frame(8'h81, 0, 10, -1, 8'h00, -1);
    chk("pre_rst_tx", tx, 1'b0);
    reset = 1'b1;
    tick();
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_irpt", uart_irpt, 1'b0);
    chk("midrst_ready", uart_out.mem_ready, 1'b0);
    reset = 1'b0;
    do_read(32'h0);
    for (int i = 0; i < 60; i++) begin
      tick();
      chk("post_rst_irpt", uart_irpt, 1'b0);
      chk("post_rst_tx", tx, 1'b1);
    end
    start_write(8'h42);
    run_frame(8'h42, 0, 40, -1, 8'h00, -1);
    end_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
